// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: bus widths, the decoded
// instruction layout, ALU opcode bit positions and divider state encoding.
package exe_stage_pkg;

    localparam int DS_TO_ES_BUS_WD = 143;
    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int ES_TO_DS_BUS_WD = 40;

    // One-hot alu_op bit positions
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // div_op = {signed, unsigned}, mf_op / mt_op = {hi, lo}
    localparam int DIV_SIGNED   = 1;
    localparam int DIV_UNSIGNED = 0;
    localparam int HL_HI        = 1;
    localparam int HL_LO        = 0;

    // Decoded instruction from ID, MSB first
    typedef struct packed {
        logic [11:0] alu_op;
        logic [1:0]  div_op;
        logic [1:0]  mf_op;
        logic [1:0]  mt_op;
        logic        load;
        logic        src1_is_sa;
        logic        src1_is_pc;
        logic        src2_is_imm;
        logic        src2_is_zimm;
        logic        src2_is_8;
        logic        gr_we;
        logic        mem_we;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] pc;
    } ds_to_es_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/exe_div.sv
// Iterative restoring divider: one quotient bit per cycle over 32 cycles on
// magnitudes, sign correction applied on the outputs. Result is held in DONE
// until the owner acknowledges it.
module exe_div
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [31:0] q,
    output logic [31:0] r
);

    div_state_t  state;
    div_state_t  next_state;
    logic [5:0]  count;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] shifted;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= DIV_IDLE;
        else       state <= next_state;
    end

    // Next state: start only from IDLE, finish after the last step, release on ack
    always_comb begin
        next_state = state;
        case (state)
            DIV_IDLE: if (start)         next_state = DIV_BUSY;
            DIV_BUSY: if (count == 6'd1) next_state = DIV_DONE;
            DIV_DONE: if (ack)           next_state = DIV_IDLE;
            default:                     next_state = DIV_IDLE;
        endcase
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted  = {rem, quo[31]};
        rem_step = shifted[31:0];
        quo_step = {quo[30:0], 1'b0};
        if (shifted >= {1'b0, dvs}) begin
            rem_step = shifted[31:0] - dvs;
            quo_step = {quo[30:0], 1'b1};
        end
    end

    // Operand latch on start, then iterate; quo doubles as the dividend shifter
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 6'd0;
            rem   <= 32'd0;
            quo   <= 32'd0;
            dvs   <= 32'd0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            count <= 6'd32;
            rem   <= 32'd0;
            quo   <= (signed_op && x[31]) ? -x : x;
            dvs   <= (signed_op && y[31]) ? -y : y;
            neg_q <= signed_op && (x[31] ^ y[31]);
            neg_r <= signed_op && x[31];
        end else if (state == DIV_BUSY) begin
            count <= count - 6'd1;
            rem   <= rem_step;
            quo   <= quo_step;
        end
    end

    // Outputs: state flags and sign-corrected results
    always_comb begin
        busy = (state == DIV_BUSY);
        done = (state == DIV_DONE);
        q    = neg_q ? -quo : quo;
        r    = neg_r ? -rem : rem;
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: valid/ready pipeline slot, ALU, HI/LO registers, divider
// control and the data-SRAM request issued on the cycle the instruction
// moves to MEM.
//
// Handshake: an instruction is accepted from ID when ds_to_es_valid and
// es_allowin are both high at a clock edge; it leaves to MEM when
// es_to_ms_valid and ms_allowin are both high (fire). Anything with a side
// effect (SRAM request, HI/LO write, divider ack) is qualified by fire.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic [ES_TO_DS_BUS_WD-1:0] es_to_ds_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
);

    ds_to_es_t   bus_r;
    logic        es_valid;
    logic        es_ready_go;
    logic        fire;
    logic        is_div;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] add_res;
    logic [31:0] alu_out;
    logic [31:0] result;

    assign is_div      = |bus_r.div_op;
    assign es_ready_go = is_div ? div_done : 1'b1;
    assign es_allowin  = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign fire        = es_valid && es_ready_go && ms_allowin;

    // Pipeline slot valid bit
    always_ff @(posedge clk) begin
        if (reset)           es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    // Instruction register; cleared on reset so every output reads zero
    always_ff @(posedge clk) begin
        if (reset)                             bus_r <= '0;
        else if (ds_to_es_valid && es_allowin) bus_r <= ds_to_es_t'(ds_to_es_bus);
    end

    exe_div u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (es_valid && is_div && !div_busy && !div_done),
        .signed_op (bus_r.div_op[DIV_SIGNED]),
        .x         (bus_r.rs_val),
        .y         (bus_r.rt_val),
        .busy      (div_busy),
        .done      (div_done),
        .ack       (fire),
        .q         (div_q),
        .r         (div_r)
    );

    // Operand selection
    always_comb begin
        src1 = bus_r.rs_val;
        if (bus_r.src1_is_sa)      src1 = {27'd0, bus_r.imm[10:6]};
        else if (bus_r.src1_is_pc) src1 = bus_r.pc;
        src2 = bus_r.rt_val;
        if (bus_r.src2_is_imm)       src2 = {{16{bus_r.imm[15]}}, bus_r.imm};
        else if (bus_r.src2_is_zimm) src2 = {16'd0, bus_r.imm};
        else if (bus_r.src2_is_8)    src2 = 32'd8;
    end

    assign add_res = src1 + src2;

    // ALU: one-hot op, results OR-ed together; shifts move src2 by src1[4:0]
    always_comb begin
        alu_out = 32'd0;
        if (bus_r.alu_op[ALU_ADD])  alu_out = alu_out | add_res;
        if (bus_r.alu_op[ALU_SUB])  alu_out = alu_out | (src1 - src2);
        if (bus_r.alu_op[ALU_SLT])  alu_out = alu_out | {31'd0, $signed(src1) < $signed(src2)};
        if (bus_r.alu_op[ALU_SLTU]) alu_out = alu_out | {31'd0, src1 < src2};
        if (bus_r.alu_op[ALU_AND])  alu_out = alu_out | (src1 & src2);
        if (bus_r.alu_op[ALU_NOR])  alu_out = alu_out | ~(src1 | src2);
        if (bus_r.alu_op[ALU_OR])   alu_out = alu_out | (src1 | src2);
        if (bus_r.alu_op[ALU_XOR])  alu_out = alu_out | (src1 ^ src2);
        if (bus_r.alu_op[ALU_SLL])  alu_out = alu_out | (src2 << src1[4:0]);
        if (bus_r.alu_op[ALU_SRL])  alu_out = alu_out | (src2 >> src1[4:0]);
        if (bus_r.alu_op[ALU_SRA])  alu_out = alu_out | 32'($signed(src2) >>> src1[4:0]);
        if (bus_r.alu_op[ALU_LUI])  alu_out = alu_out | {src2[15:0], 16'd0};
    end

    // Result mux: mfhi/mflo read the registers directly, so a write on the
    // previous fire is already visible here
    always_comb begin
        result = alu_out;
        if (bus_r.mf_op[HL_HI])      result = hi;
        else if (bus_r.mf_op[HL_LO]) result = lo;
    end

    // HI/LO update, committed only when the instruction leaves
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (fire) begin
            if (is_div) begin
                hi <= div_r;
                lo <= div_q;
            end
            if (bus_r.mt_op[HL_HI]) hi <= bus_r.rs_val;
            if (bus_r.mt_op[HL_LO]) lo <= bus_r.rs_val;
        end
    end

    assign es_to_ms_bus = {bus_r.load, bus_r.gr_we, bus_r.dest, result, bus_r.pc};
    assign es_to_ds_bus = {es_valid, es_valid && bus_r.load, bus_r.gr_we, bus_r.dest, result};

    // Request only on fire so a stalled MEM never sees a duplicate access
    assign data_sram_en    = fire && (bus_r.load || bus_r.mem_we);
    assign data_sram_wen   = {4{fire && bus_r.mem_we}};
    assign data_sram_addr  = add_res;
    assign data_sram_wdata = bus_r.rt_val;

endmodule
